// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered hex driver for a common-anode 7-segment bank.
// Define SEG7_SCAN_BLINK_EN to add per-digit blinking (BLINK_DIV parameter, I_blink port).
module seg7_scan_driver #(
    parameter int N_DIGITS  = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
`ifdef SEG7_SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV = 50_000_000
`endif
) (
    input  logic                    I_clk,
    input  logic                    I_rst_n,
    input  logic [4*N_DIGITS-1:0]   I_data,
    input  logic [N_DIGITS-1:0]     I_dp,
    input  logic [N_DIGITS-1:0]     I_en,
    input  logic                    I_load,
`ifdef SEG7_SCAN_BLINK_EN
    input  logic [N_DIGITS-1:0]     I_blink,
`endif
    output logic [6:0]              O_seg,
    output logic                    O_dp,
    output logic [N_DIGITS-1:0]     O_an,
    output logic                    O_frame
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PW-1:0]           presc;
    logic [IW-1:0]           index;
    logic                    tick;
    logic                    wrap;

    logic [4*N_DIGITS-1:0]   active_data, pending_data;
    logic [N_DIGITS-1:0]     active_dp, pending_dp;
    logic [N_DIGITS-1:0]     active_en, pending_en;
    logic                    pending_flag;

    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [N_DIGITS-1:0]     an_d;
    logic                    lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign tick = (presc == PW'(SCAN_DIV - 1));
    assign wrap = tick && (index == IW'(N_DIGITS - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            presc <= '0;
            index <= '0;
        end else if (tick) begin
            presc <= '0;
            index <= wrap ? '0 : index + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // NOTE: the display buffers are plain registers, so they take the async reset like any flop.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            active_data  <= '0;
            active_dp    <= '0;
            active_en    <= '0;
            pending_data <= '0;
            pending_dp   <= '0;
            pending_en   <= '0;
            pending_flag <= 1'b0;
        end else if (wrap) begin
            // A load landing on the wrap tick bypasses the pending stage entirely.
            if (I_load) begin
                active_data <= I_data;
                active_dp   <= I_dp;
                active_en   <= I_en;
            end else if (pending_flag) begin
                active_data <= pending_data;
                active_dp   <= pending_dp;
                active_en   <= pending_en;
            end
            pending_flag <= 1'b0;
        end else if (I_load) begin
            pending_data <= I_data;
            pending_dp   <= I_dp;
            pending_en   <= I_en;
            pending_flag <= 1'b1;
        end
    end

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        lit   = 1'b0;
        if (presc >= PW'(BLANK_CYC)) begin
            lit = active_en[index];
`ifdef SEG7_SCAN_BLINK_EN
            if (!blink_on && I_blink[index]) lit = 1'b0;
`endif
            if (lit) begin
                an_d[index] = 1'b0;
                seg_d       = hex_to_seg(active_data[4*int'(index) +: 4]);
                dp_d        = ~active_dp[index];
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_seg   <= 7'h7F;
            O_dp    <= 1'b1;
            O_an    <= '1;
            O_frame <= 1'b0;
        end else begin
            O_seg   <= seg_d;
            O_dp    <= dp_d;
            O_an    <= an_d;
            O_frame <= wrap;
        end
    end

endmodule
